// File: rtl/seq_mult_n_if.sv
// Request/result bundle for seq_mult_n: operands and mode in, product and status out.
// The master side issues requests and the slave side is the multiplier.
interface seq_mult_n_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [2*WIDTH-1:0]     Y;
    logic                   done;
    logic                   busy;
    logic [1:0]             state;

    modport master (
        output start, signed_mode, A, B,
        input  Y, done, busy, state
    );

    modport slave (
        input  start, signed_mode, A, B,
        output Y, done, busy, state
    );
endinterface

// File: rtl/seq_mult_n.sv
// Sequential shift-add multiplier, one partial product per clock.
// Signed operands are multiplied as magnitudes and the sign is applied at the end.
module seq_mult_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    seq_mult_n_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_FINISH  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     ma_q, ma_d;
    logic [WIDTH-1:0]     mb_q, mb_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   y_q, y_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 sa, sb;
    logic [2*WIDTH-1:0]   partial;

    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;
        sa      = 1'b0;
        sb      = 1'b0;
        partial = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sa      = bus.signed_mode & bus.A[WIDTH-1];
                    sb      = bus.signed_mode & bus.B[WIDTH-1];
                    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
                    ma_d    = sa ? (~bus.A + 1'b1) : bus.A;
                    mb_d    = sb ? (~bus.B + 1'b1) : bus.B;
                    neg_d   = sa ^ sb;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                partial = mb_q[cnt_q] ? ({{WIDTH{1'b0}}, ma_q} << cnt_q) : '0;
                acc_d   = acc_q + partial;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                y_d     = neg_q ? (~acc_q + 1'b1) : acc_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_COMPUTE) || (state_d == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.Y     = y_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_seq_mult_n.sv
// Directed and table-driven checks of seq_mult_n at WIDTH=8 and WIDTH=4.
module tb_seq_mult_n;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_mult_n_if #(.WIDTH(8)) if8 ();
    seq_mult_n_if #(.WIDTH(4)) if4 ();

    seq_mult_n #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    seq_mult_n #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then count edges until done (bounded).
    task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] y, output int lat, output int busy_n);
        @(posedge clk); #1;
        if8.start = 1'b1; if8.signed_mode = sm; if8.A = a; if8.B = b;
        @(posedge clk); #1;
        if8.start = 1'b0; if8.A = ~a; if8.B = ~b; if8.signed_mode = ~sm;
        lat = -1; busy_n = 0;
        for (int n = 1; n <= 40; n++) begin
            if (if8.busy) busy_n++;
            @(posedge clk); #1;
            if (if8.done) begin lat = n; break; end
        end
        y = if8.Y;
    endtask

    task automatic run4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                        output logic [7:0] y, output int lat, output int busy_n);
        @(posedge clk); #1;
        if4.start = 1'b1; if4.signed_mode = sm; if4.A = a; if4.B = b;
        @(posedge clk); #1;
        if4.start = 1'b0; if4.A = ~a; if4.B = ~b; if4.signed_mode = ~sm;
        lat = -1; busy_n = 0;
        for (int n = 1; n <= 20; n++) begin
            if (if4.busy) busy_n++;
            @(posedge clk); #1;
            if (if4.done) begin lat = n; break; end
        end
        y = if4.Y;
    endtask

    typedef struct {
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] y;
    } vec8_t;

    vec8_t vecs[8];

    initial begin
        logic [15:0] y8;
        logic [7:0]  y4;
        int lat, bn, dn, first, hold_ok;

        vecs[0] = '{1'b0, 8'd13,  8'd11,  16'd143};
        vecs[1] = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
        vecs[2] = '{1'b1, 8'h80,  8'h80,  16'h4000};
        vecs[3] = '{1'b1, 8'h80,  8'h7F,  16'hC080};
        vecs[4] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
        vecs[5] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
        vecs[6] = '{1'b1, 8'hFF,  8'h01,  16'hFFFF};
        vecs[7] = '{1'b1, 8'h00,  8'h9C,  16'h0000};

        if8.start = 1'b0; if8.signed_mode = 1'b0; if8.A = '0; if8.B = '0;
        if4.start = 1'b0; if4.signed_mode = 1'b0; if4.A = '0; if4.B = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_y",     if8.Y,     0);
        chk("rst_done",  if8.done,  0);
        chk("rst_busy",  if8.busy,  0);
        chk("rst_state", if8.state, 0);
        chk("rst_y4",    if4.Y,     0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].sm, vecs[i].a, vecs[i].b, y8, lat, bn);
            chk($sformatf("vec%0d_y", i), y8, vecs[i].y);
            chk($sformatf("vec%0d_lat", i), lat, 9);
            chk($sformatf("vec%0d_busy_cycles", i), bn, 9);
            chk($sformatf("vec%0d_busy_at_done", i), if8.busy, 0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), if8.done, 0);
            if (i == 0) begin
                hold_ok = 0;
                for (int k = 0; k < 20; k++) begin
                    if (if8.Y == 16'd143 && !if8.done) hold_ok++;
                    @(posedge clk); #1;
                end
                chk("hold_143_cycles", hold_ok, 20);
            end
        end

        // start during compute is ignored; start held into the done cycle is accepted
        @(posedge clk); #1;
        if8.start = 1'b1; if8.signed_mode = 1'b0; if8.A = 8'd7; if8.B = 8'd9;
        @(posedge clk); #1;
        if8.start = 1'b0;
        first = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 3) begin if8.start = 1'b1; if8.A = 8'd2; if8.B = 8'd2; end
            else if (n == 4) if8.start = 1'b0;
            else if (n == 6) if8.start = 1'b1;
            @(posedge clk); #1;
            if (if8.done) begin first = n; break; end
        end
        chk("ignore_lat", first, 9);
        chk("ignore_y", if8.Y, 63);
        chk("ignore_state_at_done", if8.state, 0);
        @(posedge clk); #1;
        if8.start = 1'b0;
        chk("b2b_accept_busy", if8.busy, 1);
        chk("b2b_accept_state", if8.state, 1);
        chk("b2b_done_cleared", if8.done, 0);
        first = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (if8.done) begin first = n; break; end
        end
        chk("b2b_lat", first, 9);
        chk("b2b_y", if8.Y, 4);

        // reset mid-operation discards the result
        @(posedge clk); #1;
        if8.start = 1'b1; if8.signed_mode = 1'b0; if8.A = 8'd100; if8.B = 8'd100;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_y", if8.Y, 0);
        chk("midrst_state", if8.state, 0);
        chk("midrst_busy", if8.busy, 0);
        chk("midrst_done", if8.done, 0);
        dn = 0;
        repeat (15) begin @(posedge clk); #1; if (if8.done || if8.busy) dn++; end
        chk("midrst_no_done", dn, 0);
        run8(1'b0, 8'd3, 8'd4, y8, lat, bn);
        chk("after_rst_y", y8, 12);
        chk("after_rst_lat", lat, 9);

        // WIDTH=4 instance
        run4(1'b0, 4'd15, 4'd15, y4, lat, bn);
        chk("w4_ff_y", y4, 225);
        chk("w4_ff_lat", lat, 5);
        chk("w4_ff_busy_cycles", bn, 5);
        run4(1'b1, 4'h8, 4'h1, y4, lat, bn);
        chk("w4_signed_y", y4, 8'hF8);
        chk("w4_signed_lat", lat, 5);

        for (int i = 0; i < 1000; i++) begin
            logic [3:0] a, b;
            logic       sm;
            int         ia, ib;
            logic [7:0] exp8;
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            sm = 1'($urandom_range(0, 1));
            ia = sm ? int'($signed(a)) : int'(a);
            ib = sm ? int'($signed(b)) : int'(b);
            exp8 = 8'(ia * ib);
            run4(sm, a, b, y4, lat, bn);
            chk($sformatf("w4_rand%0d_y sm=%0d a=%0h b=%0h", i, sm, a, b), y4, exp8);
            chk($sformatf("w4_rand%0d_lat", i), lat, 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
